// File: rtl/scan_scheduler.sv
// scan_scheduler: ping-pong capture sequencing for two scanner channels, shared-link
// arbitration, stall flushing and session standby control.
module scan_scheduler #(
    parameter int CAP           = 100,
    parameter int TIMEOUT       = 255,
    parameter int STANDBY_DELAY = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_req,
    input  logic       link_ready,
    input  logic [1:0] ready_to_transfer,
    input  logic [1:0] start_second_buffer,
    input  logic [7:0] data_count0,
    input  logic [7:0] data_count1,
    output logic [1:0] start_scan,
    output logic [1:0] transfer,
    output logic [1:0] flush_signal,
    output logic [1:0] go_to_standby,
    output logic       cur_ch,
    output logic       xfer_busy,
    output logic [7:0] drop_count
);
    localparam logic [7:0] CAP8 = 8'(CAP);
    localparam logic [7:0] TO8  = 8'(TIMEOUT);
    localparam logic [7:0] SD8  = 8'(STANDBY_DELAY);

    typedef enum logic [1:0] {SQ_IDLE, SQ_SCAN, SQ_WAIT} sq_t;
    typedef enum logic {AR_IDLE, AR_XFER} ar_t;

    sq_t sq, sq_n;
    ar_t ar, ar_n;
    logic [1:0][7:0] dc, wait_cnt, wait_n;
    logic [1:0] full, empty, armed, armed_n, start_scan_n, transfer_n, flush_n, cand, held, grant_now;
    logic       oth, sel, cur_ch_n, gnt, gnt_n, last_served, last_served_n, quiet, standby, standby_n;
    logic [7:0] quiet_cnt, quiet_n, drop_n;
    logic [8:0] drop_sum;

    assign dc            = {data_count1, data_count0};
    assign oth           = ~cur_ch;
    assign xfer_busy     = (ar == AR_XFER);
    assign go_to_standby = {standby, standby};
    assign cand          = ready_to_transfer & ~start_scan;
    assign sel           = (cand == 2'b11) ? ~last_served : cand[1];
    assign held          = xfer_busy ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        assign full[i]  = dc[i] >= CAP8;
        assign empty[i] = dc[i] == 8'd0;
    end

    // Sequencer: a channel's scan enable drops once its buffer fills; launches set it.
    always_comb begin
        sq_n         = sq;
        cur_ch_n     = cur_ch;
        armed_n      = armed;
        start_scan_n = start_scan & ~full;
        if (sq == SQ_IDLE) begin
            if (scan_req && empty[cur_ch]) begin
                start_scan_n[cur_ch] = 1'b1;
                armed_n[cur_ch]      = 1'b1;
                sq_n                 = SQ_SCAN;
            end
        end else if (!scan_req) begin
            if (sq == SQ_WAIT || start_scan == 2'b00) sq_n = SQ_IDLE;
        end else if (sq == SQ_WAIT || (start_second_buffer[cur_ch] && armed[cur_ch])) begin
            if (empty[oth]) begin
                start_scan_n[oth]  = 1'b1;
                armed_n[oth]       = 1'b1;
                armed_n[cur_ch]    = 1'b0;
                cur_ch_n           = oth;
                sq_n               = SQ_SCAN;
            end else begin
                sq_n = SQ_WAIT;
            end
        end
    end

    always_comb begin
        ar_n          = ar;
        gnt_n         = gnt;
        last_served_n = last_served;
        transfer_n    = 2'b00;
        grant_now     = 2'b00;
        if (ar == AR_IDLE) begin
            if (link_ready && cand != 2'b00) begin
                gnt_n           = sel;
                last_served_n   = sel;
                grant_now[sel]  = 1'b1;
                transfer_n[sel] = 1'b1;
                ar_n            = AR_XFER;
            end
        end else if (empty[gnt]) begin
            ar_n = AR_IDLE;
        end else begin
            transfer_n[gnt] = link_ready;
        end
    end

    // A grant issued this cycle counts as service, so it pre-empts a coinciding timeout.
    always_comb begin
        flush_n = 2'b00;
        wait_n  = '0;
        for (int i = 0; i < 2; i++) begin
            if (ready_to_transfer[i] && full[i] && !held[i] && !grant_now[i]) begin
                if (wait_cnt[i] == TO8 - 8'd1) flush_n[i] = 1'b1;
                else wait_n[i] = wait_cnt[i] + 8'd1;
            end
        end
        drop_sum  = {1'b0, drop_count} + 9'(flush_n[0]) + 9'(flush_n[1]);
        drop_n    = drop_sum > 9'd255 ? 8'hff : drop_sum[7:0];
        quiet     = !scan_req && empty == 2'b11 && !xfer_busy && sq == SQ_IDLE;
        quiet_n   = !quiet ? 8'd0 : (quiet_cnt == SD8 ? quiet_cnt : quiet_cnt + 8'd1);
        standby_n = scan_req ? 1'b0 : ((quiet && quiet_n == SD8) ? 1'b1 : standby);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq           <= SQ_IDLE;
            ar           <= AR_IDLE;
            cur_ch       <= 1'b0;
            armed        <= 2'b00;
            start_scan   <= 2'b00;
            transfer     <= 2'b00;
            gnt          <= 1'b0;
            last_served  <= 1'b1;
            wait_cnt     <= '0;
            flush_signal <= 2'b00;
            drop_count   <= 8'd0;
            quiet_cnt    <= 8'd0;
            standby      <= 1'b0;
        end else begin
            sq           <= sq_n;
            ar           <= ar_n;
            cur_ch       <= cur_ch_n;
            armed        <= armed_n;
            start_scan   <= start_scan_n;
            transfer     <= transfer_n;
            gnt          <= gnt_n;
            last_served  <= last_served_n;
            wait_cnt     <= wait_n;
            flush_signal <= flush_n;
            drop_count   <= drop_n;
            quiet_cnt    <= quiet_n;
            standby      <= standby_n;
        end
    end
endmodule

// File: tb/tb_scan_scheduler.sv
// tb_scan_scheduler: directed and random stimulus against a behavioural model of the
// scheduler; expected outputs are queued per clock edge and checked by a separate monitor.
module tb_scan_scheduler;
    localparam int CAP = 100, TIMEOUT = 255, SDELAY = 16;
    localparam int IDLE = 0, SCAN = 1, WAIT = 2;

    logic       clk = 1'b0, rst = 1'b0;
    logic       scan_req = 1'b0, link_ready = 1'b0;
    logic [1:0] ready_to_transfer = 2'b00, start_second_buffer = 2'b00;
    logic [7:0] data_count0 = 8'd0, data_count1 = 8'd0;
    logic [1:0] start_scan, transfer, flush_signal, go_to_standby;
    logic       cur_ch, xfer_busy;
    logic [7:0] drop_count;

    scan_scheduler #(.CAP(CAP), .TIMEOUT(TIMEOUT), .STANDBY_DELAY(SDELAY)) dut (
        .clk(clk), .rst(rst), .scan_req(scan_req), .link_ready(link_ready),
        .ready_to_transfer(ready_to_transfer), .start_second_buffer(start_second_buffer),
        .data_count0(data_count0), .data_count1(data_count1), .start_scan(start_scan),
        .transfer(transfer), .flush_signal(flush_signal), .go_to_standby(go_to_standby),
        .cur_ch(cur_ch), .xfer_busy(xfer_busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [17:0] q[$];
    logic [17:0] got, want;

    // Reference model state: what each rule of the scheduler says should be held after an edge.
    int m_sq, m_drop, m_q, m_wait[2];
    bit [1:0] m_ss, m_arm, m_tr, m_fl;
    bit m_cur, m_busy, m_g, m_last, m_sb;

    task automatic model_reset();
        m_sq = IDLE; m_drop = 0; m_q = 0; m_wait[0] = 0; m_wait[1] = 0;
        m_ss = 0; m_arm = 0; m_tr = 0; m_fl = 0;
        m_cur = 0; m_busy = 0; m_g = 0; m_last = 1; m_sb = 0;
    endtask

    task automatic handoff(inout bit [1:0] ss, inout bit [1:0] arm, inout bit cur);
        bit o = !m_cur;
        ss[o] = 1; arm[o] = 1; arm[m_cur] = 0; cur = o;
    endtask

    task automatic model_step();
        int dc[2], sq, nw[2], qc;
        bit [1:0] ss, arm, tr, fl, gnow, cand;
        bit cur, busy, g, last, sb, quiet, o;
        dc[0] = data_count0; dc[1] = data_count1;
        ss = m_ss; arm = m_arm; sq = m_sq; cur = m_cur; o = !m_cur;
        for (int i = 0; i < 2; i++) if (dc[i] >= CAP) ss[i] = 0;
        if (m_sq == IDLE) begin
            if (scan_req && dc[m_cur] == 0) begin ss[m_cur] = 1; arm[m_cur] = 1; sq = SCAN; end
        end else if (m_sq == SCAN) begin
            if (scan_req && start_second_buffer[m_cur] && m_arm[m_cur]) begin
                if (dc[o] == 0) handoff(ss, arm, cur);
                else sq = WAIT;
            end else if (!scan_req && m_ss == 0) sq = IDLE;
        end else begin
            if (!scan_req) sq = IDLE;
            else if (dc[o] == 0) begin handoff(ss, arm, cur); sq = SCAN; end
        end
        tr = 0; gnow = 0; busy = m_busy; g = m_g; last = m_last;
        cand = ready_to_transfer & ~m_ss;
        if (!m_busy) begin
            if (link_ready && cand != 0) begin
                g = (cand == 2'b11) ? !m_last : cand[1];
                gnow[g] = 1; busy = 1; last = g; tr[g] = 1;
            end
        end else if (dc[m_g] == 0) busy = 0;
        else tr[m_g] = link_ready;
        fl = 0;
        for (int i = 0; i < 2; i++) begin
            nw[i] = 0;
            if (ready_to_transfer[i] && dc[i] >= CAP && !(m_busy && m_g == i) && !gnow[i]) begin
                if (m_wait[i] + 1 == TIMEOUT) fl[i] = 1;
                else nw[i] = m_wait[i] + 1;
            end
        end
        quiet = !scan_req && dc[0] == 0 && dc[1] == 0 && !m_busy && m_sq == IDLE;
        qc = quiet ? ((m_q + 1 > SDELAY) ? SDELAY : m_q + 1) : 0;
        sb = scan_req ? 0 : ((quiet && qc == SDELAY) ? 1 : m_sb);
        m_drop = (m_drop + fl[0] + fl[1] > 255) ? 255 : m_drop + fl[0] + fl[1];
        m_sq = sq; m_ss = ss; m_arm = arm; m_cur = cur; m_busy = busy; m_g = g; m_last = last;
        m_tr = tr; m_fl = fl; m_wait[0] = nw[0]; m_wait[1] = nw[1]; m_q = qc; m_sb = sb;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(bit sr, bit lr, bit [1:0] rt, bit [1:0] sb2, int d0, int d1);
        logic [17:0] e;
        scan_req = sr; link_ready = lr; ready_to_transfer = rt; start_second_buffer = sb2;
        data_count0 = 8'(d0); data_count1 = 8'(d1);
        model_step();
        e = {m_ss, m_tr, m_fl, {2{m_sb}}, m_cur, m_busy, 8'(m_drop)};
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs", {14'd0, start_scan, transfer, flush_signal, go_to_standby,
              cur_ch, xfer_busy, drop_count}, 32'd0);
        model_reset();
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            want = q.pop_front();
            got  = {start_scan, transfer, flush_signal, go_to_standby, cur_ch, xfer_busy, drop_count};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL outputs t=%0t got ss=%b tr=%b fl=%b sb=%b cur=%b busy=%b drop=%0d want ss=%b tr=%b fl=%b sb=%b cur=%b busy=%b drop=%0d",
                         $time, got[17:16], got[15:14], got[13:12], got[11:10], got[9], got[8], got[7:0],
                         want[17:16], want[15:14], want[13:12], want[11:10], want[9], want[8], want[7:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int r0 = 0, r1 = 0;
        int cnt_tab[10] = '{0, 0, 0, 5, 50, 90, 99, 100, 101, 255};
        #3;
        do_reset();
        repeat (SDELAY - 1) drive(0, 0, 0, 0, 0, 0);
        check("standby_early", 32'(go_to_standby), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        check("standby_set", 32'(go_to_standby), 32'd3);
        drive(1, 0, 0, 0, 0, 0);
        check("launch_ch0", 32'(start_scan), 32'd1);
        check("standby_clear", 32'(go_to_standby), 32'd0);
        for (int d = 10; d <= 90; d += 20) drive(1, 0, 0, 0, d, 0);
        drive(1, 0, 0, 2'b01, 90, 0);
        check("handoff_ss", 32'(start_scan), 32'd3);
        check("handoff_cur", 32'(cur_ch), 32'd1);
        drive(1, 0, 0, 2'b01, 100, 0);
        check("ch0_full_stop", 32'(start_scan), 32'd2);
        repeat (4) drive(1, 0, 0, 2'b10, 5, 90);
        check("wait_no_handoff", 32'(start_scan), 32'd2);
        drive(1, 0, 0, 2'b10, 0, 90);
        check("wait_handoff_ss", 32'(start_scan), 32'd3);
        check("wait_handoff_cur", 32'(cur_ch), 32'd0);
        drive(1, 0, 0, 0, 0, 100);
        do_reset();
        drive(0, 1, 2'b11, 0, 50, 50);
        check("grant_ch0", 32'(transfer), 32'd1);
        drive(0, 0, 2'b11, 0, 50, 50);
        check("link_low", 32'({xfer_busy, transfer}), 32'd4);
        drive(0, 1, 2'b11, 0, 50, 50);
        check("link_high", 32'({xfer_busy, transfer}), 32'd5);
        drive(0, 1, 2'b11, 0, 0, 50);
        check("release", 32'({xfer_busy, transfer}), 32'd0);
        drive(0, 1, 2'b11, 0, 0, 50);
        check("round_robin", 32'(transfer), 32'd2);
        drive(0, 1, 2'b11, 0, 0, 50);
        do_reset();
        repeat (TIMEOUT) drive(0, 0, 2'b10, 0, 0, 100);
        check("flush_pulse", 32'({drop_count, flush_signal}), 32'h006);
        drive(0, 0, 2'b10, 0, 0, 100);
        check("flush_one_cycle", 32'(flush_signal), 32'd0);
        repeat (TIMEOUT - 2) drive(0, 0, 2'b10, 0, 0, 100);
        drive(0, 1, 2'b10, 0, 0, 100);
        check("grant_beats_flush", 32'({drop_count, transfer, flush_signal}), 32'h0018);
        do_reset();
        repeat (128 * TIMEOUT) drive(0, 0, 2'b11, 0, 100, 100);
        check("drop_saturate", 32'(drop_count), 32'd255);
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) r0 = cnt_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) r1 = cnt_tab[$urandom_range(0, 9)];
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), r0, r1);
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
